// File: rtl/bp_gshare_predictor_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared helpers for the gshare/bimodal branch predictor:
//   - bp_max_val    : all-ones value of a given counter width
//   - sat_inc       : saturating increment (clamps at all-ones of width)
//   - sat_dec       : saturating decrement (clamps at zero)
//   - ctr_reset_val : weakly not-taken reset value, 2^(width-1)-1
//   - bp_hash       : table index, PC bits optionally XORed with history
// Functions work on a 32-bit container word; callers pass the live width and
// size-cast the result back down to their own field width.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int unsigned BP_WORD_BITS = 32;

    typedef logic [BP_WORD_BITS-1:0] bp_word_t;

    function automatic bp_word_t bp_max_val(input int unsigned width);
        if (width >= BP_WORD_BITS) begin
            return '1;
        end
        return (bp_word_t'(1) << width) - bp_word_t'(1);
    endfunction

    function automatic bp_word_t sat_inc(input bp_word_t ctr, input int unsigned width);
        if (ctr >= bp_max_val(width)) begin
            return bp_max_val(width);
        end
        return ctr + bp_word_t'(1);
    endfunction

    function automatic bp_word_t sat_dec(input bp_word_t ctr, input int unsigned width);
        if (ctr == '0) begin
            return '0;
        end
        return ctr - bp_word_t'(1);
    endfunction

    // Weakly not-taken: one below the taken threshold (MSB set).
    function automatic bp_word_t ctr_reset_val(input int unsigned width);
        return (bp_word_t'(1) << (width - 1)) - bp_word_t'(1);
    endfunction

    // History is zero-extended by the caller, so short histories only fold
    // into the low index bits.
    function automatic bp_word_t bp_hash(input bp_word_t addr,
                                         input bp_word_t hist,
                                         input logic     use_hist);
        return use_hist ? (addr ^ hist) : addr;
    endfunction

endpackage

// File: rtl/bp_gshare_predictor_counter_table.sv
// ---------------------------------------------------------------------------
// bp_counter_table
// NUM_ENTRIES x CTR_BITS array of saturating counters.
// Ports:
//   clk, rst_b      : clock, asynchronous active-low reset
//   i_rd_idx        : read index (combinational read)
//   o_rd_ctr        : counter value at i_rd_idx, post-update when the write
//                     port targets the same entry this cycle (write-first)
//   i_wr_en         : apply an outcome to entry i_wr_idx at the next edge
//   i_wr_idx        : entry to update
//   i_wr_taken      : 1 = saturating increment, 0 = saturating decrement
// ---------------------------------------------------------------------------
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int NUM_ENTRIES = 1024,
    parameter int CTR_BITS    = 2,
    parameter int IDX_BITS    = $clog2(NUM_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic [CTR_BITS-1:0] o_rd_ctr,
    input  logic                i_wr_en,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic                i_wr_taken
);

    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));

    logic [CTR_BITS-1:0] r_mem [NUM_ENTRIES];

    logic [CTR_BITS-1:0] w_wr_cur;
    logic [CTR_BITS-1:0] w_wr_next;
    logic                w_bypass;

    assign w_wr_cur  = r_mem[i_wr_idx];
    assign w_wr_next = i_wr_taken ? CTR_BITS'(sat_inc(bp_word_t'(w_wr_cur), CTR_BITS))
                                  : CTR_BITS'(sat_dec(bp_word_t'(w_wr_cur), CTR_BITS));

    // A read that hits the entry being written sees the new value, so a
    // prediction never uses a counter that is one update stale.
    assign w_bypass = i_wr_en && (i_wr_idx == i_rd_idx);
    assign o_rd_ctr = w_bypass ? w_wr_next : r_mem[i_rd_idx];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mem[i] <= CTR_RST;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= w_wr_next;
        end
    end

endmodule

// File: rtl/bp_gshare_predictor.sv
// ---------------------------------------------------------------------------
// bp_gshare_predictor
// Fetch-stage branch direction predictor: a table of saturating counters
// indexed by PC bits (bimodal) or PC bits XOR global history (gshare).
// Ports:
//   clk, rst_b        : clock, asynchronous active-low reset
//   pred_valid        : prediction request this cycle
//   pred_addr         : branch PC word-address bits [IDX_BITS+1:2]
//   pred_resp_valid   : registered, high the cycle after pred_valid
//   pred_taken        : registered, MSB of the selected counter
//   pred_index        : registered, table index used (returned on update)
//   upd_valid         : branch resolved this cycle
//   upd_index         : index from the matching pred_index
//   upd_taken         : actual outcome
//   upd_pred          : prediction that was used
//   ghr               : global history register, newest outcome in bit 0
//   miss_count        : saturating mispredict count
//
// Handshake: both ports are valid-only. Every cycle with pred_valid high is
// one accepted request answered exactly one cycle later; every cycle with
// upd_valid high is one accepted resolution. There is no ready/backpressure.
// ---------------------------------------------------------------------------
module bp_gshare_predictor
    import bp_pkg::*;
#(
    parameter  int NUM_ENTRIES   = 1024,
    parameter  int CTR_BITS      = 2,
    parameter  int GHR_BITS      = 10,
    parameter  int GSHARE        = 1,
    parameter  int MISS_CNT_BITS = 16,
    localparam int IDX_BITS      = $clog2(NUM_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     pred_valid,
    input  logic [IDX_BITS+1:2]      pred_addr,
    output logic                     pred_resp_valid,
    output logic                     pred_taken,
    output logic [IDX_BITS-1:0]      pred_index,
    input  logic                     upd_valid,
    input  logic [IDX_BITS-1:0]      upd_index,
    input  logic                     upd_taken,
    input  logic                     upd_pred,
    output logic [GHR_BITS-1:0]      ghr,
    output logic [MISS_CNT_BITS-1:0] miss_count
);

    logic [GHR_BITS-1:0]      r_ghr;
    logic [MISS_CNT_BITS-1:0] r_miss;
    logic                     r_resp_valid;
    logic                     r_taken;
    logic [IDX_BITS-1:0]      r_index;

    logic [IDX_BITS-1:0]      w_pred_idx;
    logic [CTR_BITS-1:0]      w_pred_ctr;
    logic                     w_mispredict;

    // Hash uses the history as it stands before this cycle's update shifts it.
    assign w_pred_idx = IDX_BITS'(bp_hash(bp_word_t'(pred_addr),
                                          bp_word_t'(r_ghr),
                                          GSHARE != 0));

    bp_counter_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .CTR_BITS    (CTR_BITS),
        .IDX_BITS    (IDX_BITS)
    ) u_table (
        .clk        (clk),
        .rst_b      (rst_b),
        .i_rd_idx   (w_pred_idx),
        .o_rd_ctr   (w_pred_ctr),
        .i_wr_en    (upd_valid),
        .i_wr_idx   (upd_index),
        .i_wr_taken (upd_taken)
    );

    assign w_mispredict = upd_valid && (upd_taken != upd_pred);

    // Response registers; taken/index hold their last value when idle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_resp_valid <= 1'b0;
            r_taken      <= 1'b0;
            r_index      <= '0;
        end else begin
            r_resp_valid <= pred_valid;
            if (pred_valid) begin
                r_taken <= w_pred_ctr[CTR_BITS-1];
                r_index <= w_pred_idx;
            end
        end
    end

    // Non-speculative history: only resolved branches shift in. The
    // concatenate-and-truncate form also covers GHR_BITS == 1.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= GHR_BITS'({r_ghr, upd_taken});
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_miss <= '0;
        end else if (w_mispredict && (r_miss != '1)) begin
            r_miss <= r_miss + MISS_CNT_BITS'(1);
        end
    end

    assign pred_resp_valid = r_resp_valid;
    assign pred_taken      = r_taken;
    assign pred_index      = r_index;
    assign ghr             = r_ghr;
    assign miss_count      = r_miss;

endmodule

// File: tb/tb_bp_gshare_predictor.sv
// Two predictors share one stimulus stream: inst0 bimodal, inst1 gshare.
// Each is checked against its own behavioural model of the counter table.
module tb_bp_gshare_predictor;

  localparam int N  = 1024;
  localparam int IW = 10;
  localparam int GW = 10;
  localparam int MW = 4;
  localparam int CMAX = 3;
  localparam int MMAX = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          pred_valid = 1'b0;
  logic [IW+1:2] pred_addr  = '0;
  logic          upd_valid  = 1'b0;
  logic [IW-1:0] upd_index  = '0;
  logic          upd_taken  = 1'b0;
  logic          upd_pred   = 1'b0;

  logic          rv_b, tk_b, rv_g, tk_g;
  logic [IW-1:0] ix_b, ix_g;
  logic [GW-1:0] gh_b, gh_g;
  logic [MW-1:0] mc_b, mc_g;

  logic [1:0]         act_rv, act_tk;
  logic [1:0][IW-1:0] act_ix;
  logic [1:0][GW-1:0] act_gh;
  logic [1:0][MW-1:0] act_mc;
  assign act_rv = {rv_g, rv_b};
  assign act_tk = {tk_g, tk_b};
  assign act_ix = {ix_g, ix_b};
  assign act_gh = {gh_g, gh_b};
  assign act_mc = {mc_g, mc_b};

  bp_gshare_predictor #(
    .NUM_ENTRIES(N), .CTR_BITS(2), .GHR_BITS(GW), .GSHARE(0), .MISS_CNT_BITS(MW)
  ) u_bim (
    .clk(clk), .rst_b(rst_b),
    .pred_valid(pred_valid), .pred_addr(pred_addr),
    .pred_resp_valid(rv_b), .pred_taken(tk_b), .pred_index(ix_b),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghr(gh_b), .miss_count(mc_b)
  );

  bp_gshare_predictor #(
    .NUM_ENTRIES(N), .CTR_BITS(2), .GHR_BITS(GW), .GSHARE(1), .MISS_CNT_BITS(MW)
  ) u_gsh (
    .clk(clk), .rst_b(rst_b),
    .pred_valid(pred_valid), .pred_addr(pred_addr),
    .pred_resp_valid(rv_g), .pred_taken(tk_g), .pred_index(ix_g),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .ghr(gh_g), .miss_count(mc_g)
  );

  // ---------------- reference model ----------------
  int m_ctr [2][N];
  int m_ghr [2];
  int m_miss[2];
  logic [1:0] exp_rv;
  logic [1:0] exp_tk;
  int exp_ix[2];

  // scoreboard: {taken, index} per instance per predicted cycle
  logic [IW:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) m_ctr[k][i] = 1;
      m_ghr[k] = 0;
      m_miss[k] = 0;
      exp_ix[k] = 0;
    end
    exp_rv = '0;
    exp_tk = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic step(input logic pv, input int pa, input logic uv, input int ui,
                      input logic ut, input logic up);
    int idx[2];
    pred_valid = pv;
    pred_addr  = pa[IW-1:0];
    upd_valid  = uv;
    upd_index  = ui[IW-1:0];
    upd_taken  = ut;
    upd_pred   = up;
    @(posedge clk);
    idx[0] = pa;
    idx[1] = pa ^ m_ghr[1];
    if (uv) begin
      for (int k = 0; k < 2; k++) begin
        if (ut) m_ctr[k][ui] = (m_ctr[k][ui] < CMAX) ? m_ctr[k][ui] + 1 : CMAX;
        else    m_ctr[k][ui] = (m_ctr[k][ui] > 0) ? m_ctr[k][ui] - 1 : 0;
        m_ghr[k] = ((m_ghr[k] * 2) + (ut ? 1 : 0)) % N;
        if (ut != up && m_miss[k] < MMAX) m_miss[k] = m_miss[k] + 1;
      end
    end
    // a prediction sees the table after this edge's update (write-first)
    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = pv;
      if (pv) begin
        exp_ix[k] = idx[k];
        exp_tk[k] = (m_ctr[k][idx[k]] >= 2);
      end
    end
    #1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic apply_reset();
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    rst_b = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_rv[k] !== 1'b0) begin errors++; $display("FAIL reset_rv inst%0d: got %0b expected 0", k, act_rv[k]); end
      checks++; if (act_tk[k] !== 1'b0) begin errors++; $display("FAIL reset_taken inst%0d: got %0b expected 0", k, act_tk[k]); end
      checks++; if (act_ix[k] !== '0) begin errors++; $display("FAIL reset_index inst%0d: got %0h expected 0", k, act_ix[k]); end
    end
    // three mispredicted taken updates to idx 0, then reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1, 0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_mc[k] !== MW'(m_miss[k])) begin errors++; $display("FAIL pre_reset_miss inst%0d: got %0d expected %0d", k, act_mc[k], m_miss[k]); end
    end
    pred_valid = 1'b1;
    pred_addr  = '0;
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_rv[k] !== 1'b0) begin errors++; $display("FAIL async_rv inst%0d: got %0b expected 0", k, act_rv[k]); end
      checks++; if (act_gh[k] !== '0) begin errors++; $display("FAIL async_ghr inst%0d: got %0h expected 0", k, act_gh[k]); end
      checks++; if (act_mc[k] !== '0) begin errors++; $display("FAIL async_miss inst%0d: got %0d expected 0", k, act_mc[k]); end
    end
    repeat (2) @(negedge clk);
    pred_valid = 1'b0;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_rv[k] !== 1'b0) begin errors++; $display("FAIL dropped_req inst%0d: got %0b expected 0", k, act_rv[k]); end
    end
    step(1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_rv[k] !== 1'b1) begin errors++; $display("FAIL post_reset_rv inst%0d: got %0b expected 1", k, act_rv[k]); end
      checks++; if (act_tk[k] !== exp_tk[k]) begin errors++; $display("FAIL post_reset_taken inst%0d: got %0b expected %0b", k, act_tk[k], exp_tk[k]); end
      checks++; if (act_ix[k] !== IW'(exp_ix[k])) begin errors++; $display("FAIL post_reset_index inst%0d: got %0h expected %0h", k, act_ix[k], exp_ix[k]); end
      checks++; if (act_gh[k] !== GW'(m_ghr[k])) begin errors++; $display("FAIL post_reset_ghr inst%0d: got %0h expected %0h", k, act_gh[k], m_ghr[k]); end
    end
    // response lasts one cycle only
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_rv[k] !== 1'b0) begin errors++; $display("FAIL rv_drop inst%0d: got %0b expected 0", k, act_rv[k]); end
    end
  endtask

  task automatic test_saturation();
    int rows_n[4]  = '{4, 1, 3, 1};
    logic rows_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < rows_n[r]; i++) step(1'b0, 0, 1'b1, 0, rows_t[r], rows_t[r]);
      step(1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++; if (act_tk[k] !== exp_tk[k]) begin errors++; $display("FAIL sat_taken inst%0d row%0d: got %0b expected %0b", k, r, act_tk[k], exp_tk[k]); end
        checks++; if (act_ix[k] !== IW'(exp_ix[k])) begin errors++; $display("FAIL sat_index inst%0d row%0d: got %0h expected %0h", k, r, act_ix[k], exp_ix[k]); end
        checks++; if (act_gh[k] !== GW'(m_ghr[k])) begin errors++; $display("FAIL sat_ghr inst%0d row%0d: got %0h expected %0h", k, r, act_gh[k], m_ghr[k]); end
      end
    end
  endtask

  task automatic test_index_wrap();
    int addrs[3] = '{'h3ff, 'h3fe, 'h000};
    apply_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 0, 1'b1, 'h3ff, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 0, 1'b1, 'h3fe, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) begin
      step(1'b1, addrs[a], 1'b0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++; if (act_tk[k] !== exp_tk[k]) begin errors++; $display("FAIL wrap_taken inst%0d addr%0h: got %0b expected %0b", k, addrs[a], act_tk[k], exp_tk[k]); end
        checks++; if (act_ix[k] !== IW'(exp_ix[k])) begin errors++; $display("FAIL wrap_index inst%0d addr%0h: got %0h expected %0h", k, addrs[a], act_ix[k], exp_ix[k]); end
      end
    end
  endtask

  task automatic test_gshare_hash();
    logic seq[3] = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 'h100, seq[i], seq[i]);
    step(1'b1, 'h006, 1'b0, 0, 1'b0, 1'b0);
    checks++; if (act_gh[1] !== GW'('h006)) begin errors++; $display("FAIL gshare_ghr: got %0h expected 006", act_gh[1]); end
    checks++; if (act_ix[1] !== IW'('h000)) begin errors++; $display("FAIL gshare_index: got %0h expected 000", act_ix[1]); end
    checks++; if (act_ix[0] !== IW'('h006)) begin errors++; $display("FAIL bimodal_index: got %0h expected 006", act_ix[0]); end
    for (int i = 0; i < 2; i++) step(1'b0, 0, 1'b1, 0, 1'b1, 1'b1);
    step(1'b1, 'h006, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_tk[k] !== exp_tk[k]) begin errors++; $display("FAIL hash_taken inst%0d: got %0b expected %0b", k, act_tk[k], exp_tk[k]); end
      checks++; if (act_ix[k] !== IW'(exp_ix[k])) begin errors++; $display("FAIL hash_index inst%0d: got %0h expected %0h", k, act_ix[k], exp_ix[k]); end
      checks++; if (act_gh[k] !== GW'(m_ghr[k])) begin errors++; $display("FAIL hash_ghr inst%0d: got %0h expected %0h", k, act_gh[k], m_ghr[k]); end
    end
  endtask

  task automatic test_collision();
    logic outc[2] = '{1'b1, 1'b0};
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 5, 1'b1, 5, outc[r], outc[r]);
      for (int k = 0; k < 2; k++) begin
        checks++; if (act_tk[k] !== exp_tk[k]) begin errors++; $display("FAIL collide_taken inst%0d r%0d: got %0b expected %0b", k, r, act_tk[k], exp_tk[k]); end
        checks++; if (act_ix[k] !== IW'(exp_ix[k])) begin errors++; $display("FAIL collide_index inst%0d r%0d: got %0h expected %0h", k, r, act_ix[k], exp_ix[k]); end
      end
    end
    // back-to-back collisions driving entry 5 of the bimodal table up then down
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5, 1'b1, 5, (i < 3), 1'b1);
      checks++; if (act_tk[0] !== exp_tk[0]) begin errors++; $display("FAIL b2b_taken step%0d: got %0b expected %0b", i, act_tk[0], exp_tk[0]); end
    end
  endtask

  task automatic test_miss_saturation();
    logic t;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      t = 1'($urandom_range(0, 1));
      step(1'b0, 0, 1'b1, $urandom_range(0, N - 1), t, ~t);
      for (int k = 0; k < 2; k++) begin
        checks++; if (act_mc[k] !== MW'(m_miss[k])) begin errors++; $display("FAIL miss_count inst%0d upd%0d: got %0d expected %0d", k, i, act_mc[k], m_miss[k]); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      t = 1'($urandom_range(0, 1));
      step(1'b0, 0, 1'b1, $urandom_range(0, N - 1), t, t);
    end
    for (int k = 0; k < 2; k++) begin
      checks++; if (act_mc[k] !== MW'(MMAX)) begin errors++; $display("FAIL miss_hold inst%0d: got %0d expected %0d", k, act_mc[k], MMAX); end
    end
  endtask

  task automatic test_random();
    logic pv, uv, ut, up;
    int pa, ui, sel;
    logic [IW:0] got, want;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      pv = 1'($urandom_range(0, 3) != 0);
      uv = 1'($urandom_range(0, 2) != 0);
      ut = 1'($urandom_range(0, 1));
      up = 1'($urandom_range(0, 1));
      pa = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      if (sel == 0) ui = pa;
      else if (sel == 1) ui = pa ^ m_ghr[1];
      else ui = $urandom_range(0, 15);
      step(pv, pa, uv, ui, ut, up);
      for (int k = 0; k < 2; k++) if (pv) exp_q.push_back({exp_tk[k], IW'(exp_ix[k])});
      for (int k = 0; k < 2; k++) begin
        checks++; if (act_rv[k] !== exp_rv[k]) begin errors++; $display("FAIL rand_rv inst%0d cyc%0d: got %0b expected %0b", k, c, act_rv[k], exp_rv[k]); end
        if (pv && exp_q.size() > 0) begin
          want = exp_q.pop_front();
          got  = {act_tk[k], act_ix[k]};
          checks++; if (got !== want) begin errors++; $display("FAIL rand_pred inst%0d cyc%0d: got %0h expected %0h", k, c, got, want); end
        end
        checks++; if (act_gh[k] !== GW'(m_ghr[k])) begin errors++; $display("FAIL rand_ghr inst%0d cyc%0d: got %0h expected %0h", k, c, act_gh[k], m_ghr[k]); end
        checks++; if (act_mc[k] !== MW'(m_miss[k])) begin errors++; $display("FAIL rand_miss inst%0d cyc%0d: got %0d expected %0d", k, c, act_mc[k], m_miss[k]); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_reset();
    test_reset();
    test_saturation();
    test_index_wrap();
    test_gshare_hash();
    test_collision();
    test_miss_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
